rom_download_sequencer: RTL
===========================

// Module: rom_download_sequencer
// PURPOSE
// - Sits between hps_io ioctl download outputs and the core's ROM memories; owns the download write path.
// - Decodes each ioctl byte into a ROM region and drives a shared stallable write port (req/ack).
// - Back-pressures the HPS via ioctl_wait and holds core_reset through download plus a fixed settle period.
// - Replaces ad-hoc "reset | ioctl_download" gating and per-ROM address compares in the top level.
// PARAMETERS
// - ADDR_W    16                 ROM address width; ioctl_addr bits above ADDR_W-1 must be zero.
// - NREG      4                  number of ROM regions.
// - REG_BASE  {16'hA000,16'h8000,16'h7000,16'h0000}  packed NREG x ADDR_W region bases, ascending from index 0.
// - TOTAL     16'hC000           first illegal address; region NREG-1 spans [REG_BASE[NREG-1], TOTAL).
// - RST_HOLD  64                 clk_sys cycles core_reset stays high after the last write retires.
// PORTS
// - clk_sys        in   1       system clock
// - reset          in   1       synchronous, active-high
// - ioctl_download in   1       download active (level)
// - ioctl_wr       in   1       one-cycle byte strobe
// - ioctl_addr     in   25      byte address
// - ioctl_dout     in   8       byte data
// - ioctl_wait     out  1       back-pressure to the HPS
// - mem_req        out  1       write request; held until mem_ack
// - mem_ack        in   1       write accepted (1 cycle)
// - mem_sel        out  NREG    one-hot region select; valid while mem_req
// - mem_addr       out  ADDR_W  offset within region (addr - REG_BASE[sel])
// - mem_data       out  8       write data
// - core_reset     out  1       reset to the game core
// - dl_done        out  1       one-cycle pulse at end of the settle period
// - dl_err         out  1       sticky: out-of-range address or skid overflow seen; cleared on next download start
// BEHAVIOUR
// - Reset values: ioctl_wait=0, mem_req=0, mem_sel=0, mem_addr=0, mem_data=0, dl_done=0, dl_err=0, state=IDLE.
// - core_reset = reset | (state != IDLE) (combinational OR).
// - States: IDLE -> LOAD on ioctl_download=1 (clears dl_err); LOAD -> DRAIN on ioctl_download=0;
//   DRAIN -> HOLD when mem_req=0 and skid empty; HOLD -> IDLE after RST_HOLD cycles, pulsing dl_done on that transition.
// - ioctl_download=1 in DRAIN or HOLD -> LOAD; hold counter is zeroed; pending writes are kept.
// - Decode: region i when REG_BASE[i] <= addr < next base (or TOTAL for i=NREG-1). addr >= TOTAL or
//   ioctl_addr[24:ADDR_W] != 0 -> byte dropped, dl_err=1, no mem_req.
// - Latency: a legal ioctl_wr in cycle N with the port idle -> mem_req=1 with registered sel/addr/data in cycle N+1.
// - mem_req stays high with stable sel/addr/data until mem_ack; mem_ack while mem_req=0 is ignored.
// - A mem_ack in cycle M with the skid full -> skid entry presented in cycle M+1 (mem_req stays 1); otherwise mem_req=0 in cycle M+1.
// - ioctl_wait is registered: 1 from the cycle after a write is accepted until the cycle after the port and skid are both empty.
// - Skid: one entry absorbs a ioctl_wr that lands while ioctl_wait is already high.
//   A ioctl_wr with the skid full -> byte dropped and dl_err=1.
// - ioctl_wr outside LOAD (IDLE/DRAIN/HOLD) is ignored; ioctl_wr in the same cycle ioctl_download falls is still accepted.
// - Reset mid-operation: everything returns to reset values at once; an in-flight mem_req is abandoned.
//   The memory side must tolerate an unacked request being dropped.
// - Address arithmetic is unsigned, ADDR_W bits; the offset subtract never wraps for legal addresses.
// STRUCTURE
// - Shared package tp_pkg: dl_state_t enum (IDLE, LOAD, DRAIN, HOLD), the default TP ROM region
//   bases/sizes as localparams, and region index names (RGN_MAIN, RGN_SND, RGN_CHR, RGN_SPR).
// - Sub-module rom_region_decode: combinational addr -> {valid, onehot sel, offset}, parameterised by NREG/REG_BASE/TOTAL.
// - Top-level FSM, skid register and hold counter stay in rom_download_sequencer.
// TESTING
// - Zero-wait memory: download 0x0000..0xBFFF, mem_ack one cycle after req -> 49152 writes; sel switches at
//   0x7000, 0x8000, 0xA000; mem_addr = 0 at each region start; dl_err=0.
// - Stall: mem_ack delayed 5 cycles, HPS issues a wr the cycle after the accepted wr -> skid holds it;
//   both bytes written in order; ioctl_wait deasserts after the second ack.
// - Overflow: third wr while req busy and skid full -> byte dropped, dl_err=1; remaining writes unaffected.
// - Range: wr at 0xC000 and at 0x1_0000 -> no mem_req, dl_err=1; next download start clears dl_err.
// - End: ioctl_download falls with one write pending -> core_reset high until ack + 64 cycles; dl_done pulses once;
//   core_reset=0 the following cycle.
// - Restart/reset: download rises during HOLD -> state LOAD, no dl_done. reset asserted with mem_req high ->
//   next cycle all outputs at reset values; core_reset=1 while reset is high.

Source files
------------

// File: rtl/tp_pkg.sv
// tp_pkg: shared download state type and the default TP ROM region map
package tp_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} dl_state_t;
  localparam int TP_ADDR_W = 16;
  localparam int TP_NREG = 4;
  localparam int RGN_MAIN = 0;
  localparam int RGN_SND = 1;
  localparam int RGN_CHR = 2;
  localparam int RGN_SPR = 3;
  localparam logic [15:0] MAIN_BASE = 16'h0000;
  localparam logic [15:0] MAIN_SIZE = 16'h7000;
  localparam logic [15:0] SND_BASE = 16'h7000;
  localparam logic [15:0] SND_SIZE = 16'h1000;
  localparam logic [15:0] CHR_BASE = 16'h8000;
  localparam logic [15:0] CHR_SIZE = 16'h2000;
  localparam logic [15:0] SPR_BASE = 16'hA000;
  localparam logic [15:0] SPR_SIZE = 16'h2000;
  localparam logic [63:0] TP_REG_BASE = {SPR_BASE, CHR_BASE, SND_BASE, MAIN_BASE};
  localparam logic [15:0] TP_TOTAL = SPR_BASE + SPR_SIZE;
endpackage

// File: rtl/rom_region_decode.sv
// rom_region_decode: byte address -> {valid, one-hot region select, offset within region}
module rom_region_decode #(
  parameter int ADDR_W = 16,
  parameter int NREG = 4,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = '0,
  parameter logic [ADDR_W-1:0] TOTAL = '1
) (
  input  logic [24:0]       addr,
  output logic              valid,
  output logic [NREG-1:0]   sel,
  output logic [ADDR_W-1:0] offset
);
  logic [ADDR_W-1:0] a;
  logic hi_ok;
  logic [ADDR_W-1:0] off [NREG];
  assign a = addr[ADDR_W-1:0];
  assign hi_ok = addr[24:ADDR_W] == '0;
  // an address below the base wraps to a huge offset, so one compare covers both bounds
  for (genvar g = 0; g < NREG; g++) begin : g_rgn
    logic [ADDR_W-1:0] lim;
    if (g == NREG - 1) begin : g_last
      assign lim = TOTAL;
    end else begin : g_mid
      assign lim = REG_BASE[(g+1)*ADDR_W +: ADDR_W];
    end
    assign off[g] = a - REG_BASE[g*ADDR_W +: ADDR_W];
    assign sel[g] = hi_ok && off[g] < (lim - REG_BASE[g*ADDR_W +: ADDR_W]);
  end
  assign valid = |sel;
  always_comb begin
    offset = '0;
    for (int i = 0; i < NREG; i++) offset = offset | (sel[i] ? off[i] : '0);
  end
endmodule

// File: rtl/rom_download_sequencer.sv
// rom_download_sequencer: routes ioctl download bytes to ROM regions over a req/ack port
// with a one-entry skid, HPS back-pressure and a core reset held through a settle period.
module rom_download_sequencer
  import tp_pkg::*;
#(
  parameter int ADDR_W = TP_ADDR_W,
  parameter int NREG = TP_NREG,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = TP_REG_BASE,
  parameter logic [ADDR_W-1:0] TOTAL = TP_TOTAL,
  parameter int RST_HOLD = 64
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [NREG-1:0]   mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              core_reset,
  output logic              dl_done,
  output logic              dl_err
);
  localparam int HW = $clog2(RST_HOLD + 1);
  dl_state_t state, state_d;
  logic [HW-1:0] hold_cnt;
  logic dec_valid;
  logic [NREG-1:0] dec_sel;
  logic [ADDR_W-1:0] dec_off;
  logic skid_v;
  logic [NREG-1:0] skid_sel;
  logic [ADDR_W-1:0] skid_addr;
  logic [7:0] skid_data;
  logic wr_ok, ack, take, to_port, to_skid, drop, req_d, skid_d, hold_end, start;

  rom_region_decode #(
    .ADDR_W(ADDR_W), .NREG(NREG), .REG_BASE(REG_BASE), .TOTAL(TOTAL)
  ) u_dec (
    .addr(ioctl_addr), .valid(dec_valid), .sel(dec_sel), .offset(dec_off)
  );

  assign wr_ok = ioctl_wr && state == LOAD;
  assign ack = mem_req && mem_ack;
  assign take = wr_ok && dec_valid && !skid_v;
  assign to_port = take && (!mem_req || mem_ack);
  assign to_skid = take && mem_req && !mem_ack;
  assign drop = wr_ok && (!dec_valid || skid_v);
  assign req_d = (mem_req && !mem_ack) || (ack && skid_v) || to_port;
  assign skid_d = to_skid || (skid_v && !ack);
  assign hold_end = hold_cnt == HW'(RST_HOLD - 1);
  assign start = state == IDLE && ioctl_download;
  assign core_reset = reset || state != IDLE;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = ioctl_download ? LOAD : IDLE;
      LOAD:    state_d = ioctl_download ? LOAD : DRAIN;
      DRAIN:   state_d = ioctl_download ? LOAD : (!mem_req && !skid_v) ? HOLD : DRAIN;
      HOLD:    state_d = ioctl_download ? LOAD : hold_end ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      ioctl_wait <= 1'b0;
      mem_req <= 1'b0;
      mem_sel <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      skid_v <= 1'b0;
      skid_sel <= '0;
      skid_addr <= '0;
      skid_data <= '0;
      dl_done <= 1'b0;
      dl_err <= 1'b0;
    end else begin
      state <= state_d;
      hold_cnt <= (state == HOLD && state_d == HOLD) ? hold_cnt + 1'b1 : '0;
      dl_done <= state == HOLD && state_d == IDLE;
      dl_err <= start ? 1'b0 : (dl_err || drop);
      ioctl_wait <= req_d || skid_d;
      mem_req <= req_d;
      skid_v <= skid_d;
      if (ack && skid_v) begin
        mem_sel <= skid_sel;
        mem_addr <= skid_addr;
        mem_data <= skid_data;
      end else if (to_port) begin
        mem_sel <= dec_sel;
        mem_addr <= dec_off;
        mem_data <= ioctl_dout;
      end
      if (to_skid) begin
        skid_sel <= dec_sel;
        skid_addr <= dec_off;
        skid_data <= ioctl_dout;
      end
    end
  end
endmodule
